fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side consumer of the async FIFO; sits in the rclk domain directly downstream of the FIFO read port (rempty/rinc/rdata).
- Converts the FIFO pop interface into a valid/ready streaming master, using a 2-entry skid buffer.
- Sustains 1 word/cycle with no combinational path from m_ready to rinc.
- FIFO read data is first-word fall-through: rdata is valid in any cycle where rempty=0, and the pop takes effect at the rising clk edge when rinc=1.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and of m_data.
- CNT_WIDTH, 16, width of the transfer counter (used only with FIFO_RD_STAT_EN).

Ports:
- clk  input  1  read-domain clock (same clock as the FIFO rclk).
- rst  input  1  reset, asynchronous and active-high; one clock.
- rempty  input  1  FIFO empty flag (rclk domain).
- rdata  input  DATA_WIDTH  FIFO head word, valid when rempty=0.
- rinc  output  1  FIFO pop strobe.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  output word.
- occupancy  output  2  skid-buffer fill, 0..2.
- xfer_cnt  output  CNT_WIDTH  accepted-transfer count; present only with FIFO_RD_STAT_EN.

Behaviour:
- Definitions: push = rinc; pop = m_valid & m_ready.
- rinc = ~rst & ~rempty & (state != FULL). It depends only on registered state, rst and rempty; never on m_ready.
- State machine, registered, encoding equals occupancy:
  - EMPTY (0): push -> HALF.
  - HALF (1): push & ~pop -> FULL; ~push & pop -> EMPTY; push & pop -> HALF; neither -> HALF.
  - FULL (2): pop -> HALF; otherwise stay. push is impossible in FULL.
- Storage: head register drives m_data; tail register holds the second word.
  - Push into EMPTY, or into HALF together with pop: rdata -> head.
  - Push into HALF without pop: rdata -> tail.
  - Pop in FULL: tail -> head.
  - Head and tail hold otherwise.
- m_valid = (state != EMPTY), registered/state-derived.
- m_data stays stable while m_valid=1 and m_ready=0.
- Latency: word present at FIFO with rempty=0 and state EMPTY -> m_valid=1 on the next clk edge (1 cycle).
- Throughput: in HALF with continuous m_ready=1 and rempty=0, push and pop every cycle, 1 word/cycle.
- Backpressure: m_ready=0 fills the buffer to FULL, then rinc deasserts; no word is lost or duplicated.
- m_ready while m_valid=0: ignored.
- rempty toggling: a pop is issued only in cycles where rempty=0. A gap in FIFO data produces a gap in m_valid with order preserved.
- Reset asserted (async, any time, including mid-transfer):
  - Immediately: state=EMPTY, m_valid=0, m_data=0, head=tail=0, occupancy=0, rinc=0.
  - Buffered words are discarded; the FIFO read pointer is not affected by this block.
- Reset release: first possible rinc is in the first cycle after rst falls.

Optional Feature:
- Macro: FIFO_RD_STAT_EN.
- Defined:
  - xfer_cnt port exists. It increments by 1 on every pop, wraps modulo 2^CNT_WIDTH, resets to 0 asynchronously, and is registered (updates the edge after the pop).
- Undefined:
  - Port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: FULL holding 0x11/0x22, assert rst -> same cycle m_valid=0, occupancy=0, rinc=0, m_data=0; after release, FIFO head 0x33 -> m_data=0x33 one cycle later.
- Streaming: FIFO preloaded 0x01..0x08, m_ready=1 constant -> rinc high 8 consecutive cycles; m_data 0x01..0x08 on consecutive cycles starting 1 cycle after the first rinc; xfer_cnt=8.
- Backpressure: preload 0xA0..0xA3, m_ready=0 -> exactly 2 rinc pulses, occupancy=2, m_data=0xA0 stable; raise m_ready -> output order A0,A1,A2,A3 with no drops.
- Single word: rempty low 1 cycle with rdata=0x5A, m_ready=0 for 5 cycles -> m_valid=1, m_data=0x5A held, occupancy=1, no further rinc.
- Ready without data: rempty=1, m_ready toggling -> rinc=0, m_valid=0, xfer_cnt unchanged.
- Counter wrap (FIFO_RD_STAT_EN, CNT_WIDTH=4): 17 transfers -> xfer_cnt=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter: turns the FIFO first-word-fall-through pop port into a
// valid/ready master through a 2-entry skid buffer. FIFO_RD_STAT_EN adds the xfer_cnt counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  push;
  logic                  pop;

  // The pop strobe looks only at registered state, so m_ready never reaches rinc.
  assign rinc      = ~rst & ~rempty & (state_q != FULL);
  assign push      = rinc;
  assign m_valid   = (state_q != EMPTY);
  assign pop       = m_valid & m_ready;
  assign m_data    = head_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = HALF;
          head_d  = rdata;
        end
      end
      HALF: begin
        if (push && !pop) begin
          state_d = FULL;
          tail_d  = rdata;
        end else if (push && pop) begin
          head_d = rdata;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = HALF;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FIFO_RD_STAT_EN
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (pop) begin
      xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT,
// directed words go into an expected queue, and a monitor checks every accepted word.
module tb_fifo_rd_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rempty = 1'b1;
   logic [7:0] rdata = 8'h00;
   logic       rinc;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic [1:0] occupancy;
`ifdef FIFO_RD_STAT_EN
   logic [3:0] xfer_cnt;
`endif

   fifo_rd_stream #(
      .DATA_WIDTH(8),
      .CNT_WIDTH (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rempty   (rempty),
      .rdata    (rdata),
      .rinc     (rinc),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .occupancy(occupancy)
`ifdef FIFO_RD_STAT_EN
      ,
      .xfer_cnt (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         cmp_count = 0;
   int         fail_count = 0;
   int         cyc = 0;
   logic       pop_pend = 1'b0;
   int         rinc_count = 0;
   int         first_rinc_cyc = -1;
   int         last_rinc_cyc = -1;
   int         xfer_seen = 0;
   int         first_pop_cyc = -1;
   int         last_pop_cyc = -1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      cmp_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic clearStats();
      rinc_count = 0;
      first_rinc_cyc = -1;
      last_rinc_cyc = -1;
      xfer_seen = 0;
      first_pop_cyc = -1;
      last_pop_cyc = -1;
   endtask

   // Loads n words (base, base+step, ...) into the FIFO model and the expected queue.
   task automatic applyStimulus(input logic ready_val, input logic [7:0] base, input int n, input logic [7:0] step);
      logic [7:0] w;
      @(negedge clk);
      clearStats();
      m_ready = ready_val;
      for (int i = 0; i < n; i++) begin
         w = 8'(base + 8'(i) * step);
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
   endtask

   // FIFO model: pops on the edge after rinc was seen high, presents the head FWFT.
   always @(negedge clk) begin
      cyc++;
      #1;
      if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
      rempty = (fifo_q.size() == 0);
      rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      #1;
      pop_pend = rinc;
      if (rinc) begin
         rinc_count++;
         if (first_rinc_cyc < 0) first_rinc_cyc = cyc;
         last_rinc_cyc = cyc;
      end
   end

   // Monitor: every word that will be accepted at the next edge is scored.
   always @(negedge clk) begin
      logic [7:0] exp_word;
      #2;
      if (m_valid && m_ready) begin
         xfer_seen++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         last_pop_cyc = cyc;
         if (exp_q.size() == 0) begin
            cmp_count++;
            fail_count++;
            $display("[TB] FAIL unexpected_word actual=0x%0h required=none", m_data);
         end else begin
            exp_word = exp_q.pop_front();
            checkOutput("stream_word", {24'h0, m_data}, {24'h0, exp_word});
         end
      end
   end

   initial begin
      // Reset state
      @(negedge clk);
      #3;
      checkOutput("reset_m_valid", {31'h0, m_valid}, 32'h0);
      checkOutput("reset_occupancy", {30'h0, occupancy}, 32'h0);
      checkOutput("reset_rinc", {31'h0, rinc}, 32'h0);
      checkOutput("reset_m_data", {24'h0, m_data}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Streaming 0x01..0x08 with m_ready held high
      applyStimulus(1'b1, 8'h01, 8, 8'h01);
      repeat (12) @(negedge clk);
      #3;
      checkOutput("stream_rinc_count", rinc_count, 8);
      checkOutput("stream_rinc_span", last_rinc_cyc - first_rinc_cyc, 7);
      checkOutput("stream_latency", first_pop_cyc - first_rinc_cyc, 1);
      checkOutput("stream_pop_span", last_pop_cyc - first_pop_cyc, 7);
      checkOutput("stream_xfers", xfer_seen, 8);
      checkOutput("stream_idle_valid", {31'h0, m_valid}, 32'h0);
`ifdef FIFO_RD_STAT_EN
      checkOutput("stream_xfer_cnt", {28'h0, xfer_cnt}, 32'd8);
`endif

      // Backpressure: only two words may be pulled while m_ready is low
      applyStimulus(1'b0, 8'hA0, 4, 8'h01);
      repeat (5) @(negedge clk);
      #3;
      checkOutput("bp_rinc_count", rinc_count, 2);
      checkOutput("bp_occupancy", {30'h0, occupancy}, 32'd2);
      checkOutput("bp_m_valid", {31'h0, m_valid}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #3;
         checkOutput("bp_head_stable", {24'h0, m_data}, 32'hA0);
      end
      @(negedge clk);
      m_ready = 1'b1;
      repeat (8) @(negedge clk);
      #3;
      checkOutput("bp_rinc_total", rinc_count, 4);
      checkOutput("bp_xfers", xfer_seen, 4);
      checkOutput("bp_drained", exp_q.size(), 0);

      // Single word held under backpressure
      applyStimulus(1'b0, 8'h5A, 1, 8'h00);
      repeat (5) @(negedge clk);
      #3;
      checkOutput("single_rinc_count", rinc_count, 1);
      checkOutput("single_m_valid", {31'h0, m_valid}, 32'h1);
      checkOutput("single_m_data", {24'h0, m_data}, 32'h5A);
      checkOutput("single_occupancy", {30'h0, occupancy}, 32'd1);
      @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      #3;
      checkOutput("single_drained", exp_q.size(), 0);

      // Ready toggling with nothing in the FIFO
      begin
`ifdef FIFO_RD_STAT_EN
         logic [3:0] cnt_before;
         cnt_before = xfer_cnt;
`endif
         @(negedge clk);
         clearStats();
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m_ready = ~m_ready;
         end
         #3;
         checkOutput("nodata_rinc_count", rinc_count, 0);
         checkOutput("nodata_m_valid", {31'h0, m_valid}, 32'h0);
         checkOutput("nodata_xfers", xfer_seen, 0);
`ifdef FIFO_RD_STAT_EN
         checkOutput("nodata_xfer_cnt", {28'h0, xfer_cnt}, {28'h0, cnt_before});
`endif
      end

      // Reset while FULL with 0x11/0x22, then 0x33 after release
      applyStimulus(1'b0, 8'h11, 2, 8'h11);
      repeat (3) @(negedge clk);
      #3;
      checkOutput("mid_full_occupancy", {30'h0, occupancy}, 32'd2);
      checkOutput("mid_full_head", {24'h0, m_data}, 32'h11);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      fifo_q.push_back(8'h33);
      exp_q.push_back(8'h33);
      #3;
      checkOutput("mid_rst_m_valid", {31'h0, m_valid}, 32'h0);
      checkOutput("mid_rst_occupancy", {30'h0, occupancy}, 32'h0);
      checkOutput("mid_rst_rinc", {31'h0, rinc}, 32'h0);
      checkOutput("mid_rst_m_data", {24'h0, m_data}, 32'h0);
`ifdef FIFO_RD_STAT_EN
      checkOutput("mid_rst_xfer_cnt", {28'h0, xfer_cnt}, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #3;
      checkOutput("post_rst_m_valid", {31'h0, m_valid}, 32'h1);
      checkOutput("post_rst_m_data", {24'h0, m_data}, 32'h33);
      checkOutput("post_rst_occupancy", {30'h0, occupancy}, 32'd1);
      @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      #3;
      checkOutput("post_rst_drained", exp_q.size(), 0);

`ifdef FIFO_RD_STAT_EN
      // 17 transfers through a 4-bit counter wrap to 1
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 8'h40, 17, 8'h01);
      repeat (22) @(negedge clk);
      #3;
      checkOutput("wrap_xfers", xfer_seen, 17);
      checkOutput("wrap_xfer_cnt", {28'h0, xfer_cnt}, 32'd1);
`endif

      repeat (2) @(negedge clk);
      #3;
      checkOutput("final_scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
